flexsoc_irq_ctrl: RTL and testbench

Interrupt conditioning stage directly upstream of the Cortex-M3 core's `INTISR` input. It merges three sources into the per-line IRQ vector the core samples:

- host-written CSR level bits;
- host-written CSR edge strobes, stretched into fixed-length pulses;
- IRQ lines scanned back from the remote target bridge, synchronised and edge-detected.

It also exposes per-line pulse-pending status and a saturating event counter for CSR readback.

---
 rtl/flexsoc_irq_pkg.sv | 15 +
 rtl/flexsoc_irq_ctrl_if.sv | 32 +++
 rtl/irq_pulse_cell.sv | 63 ++++++
 rtl/flexsoc_irq_ctrl.sv | 72 +++++++
 tb/tb_flexsoc_irq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flexsoc_irq_pkg.sv
// Shared constants and helpers for the flexsoc IRQ conditioning stage.
//   EVT_CNT_W : width of the saturating event counter
//   IRQ_MAX   : largest legal NUM_IRQ
//   cnt_w()   : pulse down-counter width for a given pulse length
package flexsoc_irq_pkg;

   localparam int unsigned EVT_CNT_W = 16;
   localparam int unsigned IRQ_MAX   = 240;

   // Wide enough to hold the value len itself.
   function automatic int unsigned cnt_w(int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/flexsoc_irq_ctrl_if.sv
// Host/remote side bundle of the IRQ conditioning stage.
//   master : CSR/bridge side, drives the request inputs, observes the status
//   slave  : flexsoc_irq_ctrl side
//   CSR_LEVEL, CSR_EDGE_WR, CSR_EDGE_DATA, REMOTE_IRQ, REMOTE_EN, CNT_CLR : requests
//   IRQ, EDGE_PEND, EVT_CNT : conditioned vector to the core and CSR readback
interface flexsoc_irq_ctrl_if
   import flexsoc_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 32
) ();

   logic [NUM_IRQ-1:0]   CSR_LEVEL;
   logic                 CSR_EDGE_WR;
   logic [NUM_IRQ-1:0]   CSR_EDGE_DATA;
   logic [NUM_IRQ-1:0]   REMOTE_IRQ;
   logic                 REMOTE_EN;
   logic                 CNT_CLR;
   logic [NUM_IRQ-1:0]   IRQ;
   logic [NUM_IRQ-1:0]   EDGE_PEND;
   logic [EVT_CNT_W-1:0] EVT_CNT;

   modport master (
      output CSR_LEVEL, CSR_EDGE_WR, CSR_EDGE_DATA, REMOTE_IRQ, REMOTE_EN, CNT_CLR,
      input  IRQ, EDGE_PEND, EVT_CNT
   );

   modport slave (
      input  CSR_LEVEL, CSR_EDGE_WR, CSR_EDGE_DATA, REMOTE_IRQ, REMOTE_EN, CNT_CLR,
      output IRQ, EDGE_PEND, EVT_CNT
   );

endinterface

// File: rtl/irq_pulse_cell.sv
// One IRQ line: remote synchroniser, history flop, rising-edge detect and
// retriggerable pulse down-counter.
//   CLK, PORESETn : clock, async active-low reset
//   remote_irq    : asynchronous level from the remote bridge
//   remote_en     : allows remote rising edges to start a pulse
//   csr_ld        : CSR edge strobe already qualified for this line
//   ld            : this line loads its counter this cycle
//   pend          : pulse in progress (counter non-zero)
module irq_pulse_cell
   import flexsoc_irq_pkg::*;
#(
   parameter int unsigned PULSE_LEN   = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic PORESETn,
   input  logic remote_irq,
   input  logic remote_en,
   input  logic csr_ld,
   output logic ld,
   output logic pend
);

   localparam int unsigned CNT_W = cnt_w(PULSE_LEN);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   synced;
   logic                   rise;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   assign synced = sync_q[SYNC_STAGES-1];
   assign rise   = synced & ~hist_q;
   // A CSR strobe and a remote edge together still give a single load.
   assign ld     = csr_ld | (remote_en & rise);
   assign pend   = (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = CNT_LOAD;                  // retrigger reloads, never adds
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // History follows the synced level even while disabled, so enabling with
   // the line already high does not fake an edge.
   always_ff @(posedge CLK or negedge PORESETn) begin
      if (!PORESETn) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], remote_irq};
         hist_q <= synced;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/flexsoc_irq_ctrl.sv
// IRQ conditioning stage in front of the Cortex-M3 INTISR input. Merges CSR
// level bits, CSR edge strobes and synchronised remote edges into one
// registered vector, with pulse-pending readback and a saturating count of
// cycles in which any pulse was loaded.
//   CLK, PORESETn : clock, async active-low reset
//   bus (slave)   : CSR/remote requests in; IRQ, EDGE_PEND, EVT_CNT out
// NUM_IRQ must be 1..IRQ_MAX, PULSE_LEN >= 1, SYNC_STAGES >= 2, and NUM_IRQ
// must match the width of the connected interface.
module flexsoc_irq_ctrl
   import flexsoc_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = 32,
   parameter int unsigned PULSE_LEN   = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               CLK,
   input  logic               PORESETn,
   flexsoc_irq_ctrl_if.slave  bus
);

   localparam logic [EVT_CNT_W-1:0] EVT_MAX = '1;

   logic [NUM_IRQ-1:0]   lvl_q;
   logic [NUM_IRQ-1:0]   ld;
   logic [NUM_IRQ-1:0]   pend;
   logic                 ld_any;
   logic [EVT_CNT_W-1:0] evt_q;
   logic [EVT_CNT_W-1:0] evt_d;

   for (genvar i = 0; i < NUM_IRQ; i++) begin : gen_cell
      irq_pulse_cell #(
         .PULSE_LEN   (PULSE_LEN),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_cell (
         .CLK        (CLK),
         .PORESETn   (PORESETn),
         .remote_irq (bus.REMOTE_IRQ[i]),
         .remote_en  (bus.REMOTE_EN),
         .csr_ld     (bus.CSR_EDGE_WR & bus.CSR_EDGE_DATA[i]),
         .ld         (ld[i]),
         .pend       (pend[i])
      );
   end

   assign ld_any = |ld;

   always_comb begin
      evt_d = evt_q;
      if (bus.CNT_CLR) begin
         evt_d = '0;                        // clear beats a same-cycle increment
      end else if (ld_any && (evt_q != EVT_MAX)) begin
         evt_d = evt_q + EVT_CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge PORESETn) begin
      if (!PORESETn) begin
         lvl_q <= '0;
         evt_q <= '0;
      end else begin
         lvl_q <= bus.CSR_LEVEL;
         evt_q <= evt_d;
      end
   end

   // Both terms come straight from flops, so the OR cannot glitch low when a
   // pulse ends under a held level.
   assign bus.IRQ       = lvl_q | pend;
   assign bus.EDGE_PEND = pend;
   assign bus.EVT_CNT   = evt_q;

endmodule

// File: tb/tb_flexsoc_irq_ctrl.sv
module tb_flexsoc_irq_ctrl;

   typedef struct packed {
      logic [31:0] irq;
      logic [31:0] pend;
      logic [15:0] evt;
   } obs_t;

   logic CLK;
   logic PORESETn;
   int   checks;
   int   failures;
   obs_t exp_q[$];
   obs_t e;
   obs_t got;

   flexsoc_irq_ctrl_if #(.NUM_IRQ(32)) bus_if ();

   flexsoc_irq_ctrl #(
      .NUM_IRQ     (32),
      .PULSE_LEN   (4),
      .SYNC_STAGES (2)
   ) dut (
      .CLK      (CLK),
      .PORESETn (PORESETn),
      .bus      (bus_if)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [31:0] irq, input logic [31:0] pend, input logic [15:0] evt);
      exp_q.push_back({irq, pend, evt});
   endtask

   task automatic clear_evt();
      bus_if.CNT_CLR = 1'b1;
      step();
      bus_if.CNT_CLR = 1'b0;
   endtask

   task automatic test_reset();
      PORESETn             = 1'b0;
      bus_if.CSR_LEVEL     = '1;
      bus_if.CSR_EDGE_WR   = 1'b1;
      bus_if.CSR_EDGE_DATA = '1;
      bus_if.REMOTE_IRQ    = '1;
      bus_if.REMOTE_EN     = 1'b1;
      bus_if.CNT_CLR       = 1'b1;
      repeat (3) step();
      got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
      checks++;
      if (got !== 80'd0) begin
         failures++;
         $display("FAIL reset_hold got=%h expected=0", got);
      end
      bus_if.CSR_EDGE_WR = 1'b0;
      bus_if.REMOTE_EN   = 1'b0;
      bus_if.CNT_CLR     = 1'b0;
      PORESETn           = 1'b1;
      #1;
      checks++;
      if (bus_if.IRQ !== 32'h0) begin
         failures++;
         $display("FAIL reset_release_pre irq=%h expected=0", bus_if.IRQ);
      end
      push(32'hFFFF_FFFF, 32'h0, 16'h0);
      push(32'h0, 32'h0, 16'h0);
      push(32'h0, 32'h0, 16'h0);
      push(32'h0, 32'h0, 16'h0);
      push(32'h0, 32'h0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 0) begin
            bus_if.CSR_LEVEL  = '0;
            bus_if.REMOTE_IRQ = '0;
         end
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL reset_release cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
   endtask

   task automatic test_csr_pulse();
      clear_evt();
      bus_if.CSR_EDGE_WR   = 1'b1;
      bus_if.CSR_EDGE_DATA = 32'h0000_0005;
      for (int i = 0; i < 4; i++) push(32'h5, 32'h5, 16'd1);
      push(32'h0, 32'h0, 16'd1);
      push(32'h0, 32'h0, 16'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         bus_if.CSR_EDGE_WR = 1'b0;
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL csr_pulse cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
   endtask

   task automatic test_retrigger();
      clear_evt();
      bus_if.CSR_EDGE_WR   = 1'b1;
      bus_if.CSR_EDGE_DATA = 32'h0000_0008;
      push(32'h8, 32'h8, 16'd1);
      push(32'h8, 32'h8, 16'd1);
      for (int i = 0; i < 4; i++) push(32'h8, 32'h8, 16'd2);
      push(32'h0, 32'h0, 16'd2);
      for (int i = 0; i < 7; i++) begin
         step();
         bus_if.CSR_EDGE_WR = (i == 1);
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL retrigger cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
   endtask

   task automatic test_level_overlap();
      clear_evt();
      bus_if.CSR_LEVEL     = 32'h0000_0010;
      bus_if.CSR_EDGE_WR   = 1'b1;
      bus_if.CSR_EDGE_DATA = 32'h0000_0010;
      for (int i = 0; i < 4; i++) push(32'h10, 32'h10, 16'd1);
      push(32'h10, 32'h0, 16'd1);
      push(32'h10, 32'h0, 16'd1);
      push(32'h0, 32'h0, 16'd1);
      for (int i = 0; i < 7; i++) begin
         step();
         bus_if.CSR_EDGE_WR = 1'b0;
         if (i == 5) bus_if.CSR_LEVEL = '0;
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL level_overlap cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
   endtask

   task automatic test_remote_edge();
      clear_evt();
      bus_if.REMOTE_EN = 1'b1;
      #2;
      bus_if.REMOTE_IRQ[7] = 1'b1;          // mid-cycle, before the first sampling edge
      push(32'h0, 32'h0, 16'd0);
      push(32'h0, 32'h0, 16'd0);
      for (int i = 0; i < 4; i++) push(32'h80, 32'h80, 16'd1);
      for (int i = 0; i < 4; i++) push(32'h0, 32'h0, 16'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL remote_edge cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
      bus_if.REMOTE_EN = 1'b0;
      repeat (2) step();
      bus_if.REMOTE_EN = 1'b1;
      for (int i = 0; i < 6; i++) push(32'h0, 32'h0, 16'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL remote_enable_high cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
      bus_if.REMOTE_EN  = 1'b0;
      bus_if.REMOTE_IRQ = '0;
      repeat (4) step();
   endtask

   task automatic test_simultaneous();
      clear_evt();
      bus_if.REMOTE_EN     = 1'b1;
      bus_if.CSR_EDGE_DATA = 32'h0000_0002;
      for (int pass = 0; pass < 2; pass++) begin
         logic [15:0] ev0;
         logic [15:0] ev1;
         ev0 = (pass == 0) ? 16'd0 : 16'd1;
         ev1 = (pass == 0) ? 16'd1 : 16'd0;
         bus_if.REMOTE_IRQ[1] = 1'b1;
         push(32'h0, 32'h0, ev0);
         push(32'h0, 32'h0, ev0);
         for (int i = 0; i < 4; i++) push(32'h2, 32'h2, ev1);
         push(32'h0, 32'h0, ev1);
         for (int i = 0; i < 7; i++) begin
            step();
            // Strobe lands on the same edge as the synchronised remote rise.
            bus_if.CSR_EDGE_WR = (i == 1);
            bus_if.CNT_CLR     = (i == 1) && (pass == 1);
            e   = exp_q.pop_front();
            got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL simultaneous pass=%0d cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                        pass, i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
            end
         end
         bus_if.REMOTE_IRQ = '0;
         repeat (4) step();
      end
      bus_if.REMOTE_EN = 1'b0;
   endtask

   task automatic test_saturation_reset();
      clear_evt();
      bus_if.CSR_EDGE_WR   = 1'b1;
      bus_if.CSR_EDGE_DATA = 32'h0000_0001;
      repeat (65534) step();
      push(32'h1, 32'h1, 16'hFFFE);
      push(32'h1, 32'h1, 16'hFFFF);
      push(32'h1, 32'h1, 16'hFFFF);
      push(32'h1, 32'h1, 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) repeat (4465) step();
         if (i == 3) bus_if.CSR_EDGE_WR = 1'b0;
         if (i != 0) step();
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL saturation idx=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
      #2;
      PORESETn = 1'b0;
      #1;
      got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
      checks++;
      if (got !== 80'd0) begin
         failures++;
         $display("FAIL midpulse_reset_async got=%h expected=0", got);
      end
      repeat (2) step();
      PORESETn = 1'b1;
      for (int i = 0; i < 5; i++) push(32'h0, 32'h0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         e   = exp_q.pop_front();
         got = {bus_if.IRQ, bus_if.EDGE_PEND, bus_if.EVT_CNT};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL midpulse_reset_after cyc=%0d irq=%h pend=%h evt=%h expected irq=%h pend=%h evt=%h",
                     i, got.irq, got.pend, got.evt, e.irq, e.pend, e.evt);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_csr_pulse();
      test_retrigger();
      test_level_overlap();
      test_remote_edge();
      test_simultaneous();
      test_saturation_reset();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
